// File: rtl/buf_executor_mc_pkg.sv
// Shared types for the command-buffer executor: FSM states, opcode classes and
// the opcode classification helper.
package buf_executor_mc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRELOAD,
        ST_FETCH,
        ST_DELAY,
        ST_WAIT_INT,
        ST_ERROR
    } state_e;

    typedef enum logic [2:0] {
        OPC_DELAY,
        OPC_WAIT,
        OPC_OUT,
        OPC_END,
        OPC_RSVD
    } op_class_e;

    localparam logic [5:0] END_IDX = 6'h3F;

    // END shares the OUT range; its index slot is the only one OUT cannot reach.
    function automatic op_class_e classify(input logic [7:0] op);
        op_class_e c;
        case (op[7:6])
            2'b00:   c = OPC_DELAY;
            2'b01:   c = OPC_WAIT;
            2'b10:   c = (op[5:0] == END_IDX) ? OPC_END : OPC_OUT;
            default: c = OPC_RSVD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/buf_executor_mc_decode.sv
// Combinational split of a FIFO head word into opcode class, output index,
// payload and interrupt mask. Only the top 8 opcode bits take part in decode.
module buf_executor_mc_decode
    import buf_executor_mc_pkg::*;
#(
    parameter int OP_WIDTH   = 8,
    parameter int DATA_WIDTH = 32,
    parameter int INT_WIDTH  = 32
) (
    input  logic [OP_WIDTH+DATA_WIDTH-1:0] word_i,
    output op_class_e                      op_class_o,
    output logic [5:0]                     idx_o,
    output logic [DATA_WIDTH-1:0]          payload_o,
    output logic [INT_WIDTH-1:0]           mask_o
);

    logic [7:0] op;

    assign op         = word_i[OP_WIDTH+DATA_WIDTH-1 -: 8];
    assign op_class_o = classify(op);
    assign idx_o      = op[5:0];
    assign payload_o  = word_i[DATA_WIDTH-1:0];
    assign mask_o     = word_i[INT_WIDTH-1:0];

    if (OP_WIDTH > 8) begin : g_op_lsb
        logic unused_op_lsb;
        assign unused_op_lsb = ^word_i[DATA_WIDTH +: OP_WIDTH-8];
    end

endmodule

// File: rtl/buf_executor_mc.sv
// Command-buffer executor. States: IDLE wait start | PRELOAD wait FIFO fill |
// FETCH decode/pop head | DELAY count down | WAIT_INT wait mask+busy | ERROR hold until abort.
module buf_executor_mc
    import buf_executor_mc_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int OP_WIDTH    = 8,
    parameter int INT_WIDTH   = 32,
    parameter int COUNT_WIDTH = 32,
    parameter int START_LEVEL = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           fifo_empty,
    input  logic [OP_WIDTH+DATA_WIDTH-1:0] fifo_data,
    output logic                           fifo_read,
    input  logic [COUNT_WIDTH-1:0]         fifo_global_count,
    input  logic [COUNT_WIDTH-1:0]         fifo_local_count,
    input  logic                           ext_out_reg_busy,
    input  logic [INT_WIDTH-1:0]           ext_pending_ints,
    output logic [5:0]                     out_reg_addr,
    output logic [DATA_WIDTH-1:0]          out_reg_data,
    output logic                           out_reg_write,
    output logic                           busy,
    output logic                           done,
    output logic                           aborted,
    output logic                           underrun,
    output logic                           error,
    output logic [COUNT_WIDTH-1:0]         cmd_count
);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   delay_q, delay_d;
    logic [INT_WIDTH-1:0]    mask_q, mask_d;
    logic                    wr_q, wr_d;
    logic [5:0]              addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    done_q, done_d;
    logic                    aborted_q, aborted_d;
    logic                    underrun_q, underrun_d;
    logic                    error_q, error_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;

    op_class_e               cls;
    logic [5:0]              idx;
    logic [DATA_WIDTH-1:0]   payload;
    logic [INT_WIDTH-1:0]    mask;
    logic                    preload_ok;
    logic                    unused_status;

    buf_executor_mc_decode #(
        .OP_WIDTH   (OP_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .INT_WIDTH  (INT_WIDTH)
    ) u_decode (
        .word_i     (fifo_data),
        .op_class_o (cls),
        .idx_o      (idx),
        .payload_o  (payload),
        .mask_o     (mask)
    );

    assign preload_ok    = fifo_local_count >= COUNT_WIDTH'(START_LEVEL);
    assign unused_status = ^fifo_global_count;

    always_comb begin
        state_d    = state_q;
        delay_d    = delay_q;
        mask_d     = mask_q;
        wr_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        underrun_d = underrun_q;
        error_d    = error_q;
        count_d    = count_q;
        fifo_read  = 1'b0;

        if (abort) begin
            state_d   = ST_IDLE;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d    = ST_PRELOAD;
                        underrun_d = 1'b0;
                        error_d    = 1'b0;
                        count_d    = '0;
                    end
                end
                ST_PRELOAD: begin
                    if (preload_ok) state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    if (fifo_empty) begin
                        underrun_d = 1'b1;
                    end else if (!(cls == OPC_OUT && ext_out_reg_busy)) begin
                        fifo_read = 1'b1;
                        if (count_q != '1) count_d = count_q + COUNT_WIDTH'(1);
                        case (cls)
                            OPC_OUT: begin
                                wr_d   = 1'b1;
                                addr_d = idx;
                                data_d = payload;
                            end
                            OPC_DELAY: begin
                                // Countdown runs payload-1..0, giving exactly payload stall cycles.
                                if (payload != '0) begin
                                    delay_d = payload - DATA_WIDTH'(1);
                                    state_d = ST_DELAY;
                                end
                            end
                            OPC_WAIT: begin
                                mask_d  = mask;
                                state_d = ST_WAIT_INT;
                            end
                            OPC_END: begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end
                            default: begin
                                state_d = ST_ERROR;
                                error_d = 1'b1;
                            end
                        endcase
                    end
                end
                ST_DELAY: begin
                    if (delay_q == '0) state_d = ST_FETCH;
                    else               delay_d = delay_q - DATA_WIDTH'(1);
                end
                ST_WAIT_INT: begin
                    if (((ext_pending_ints & mask_q) == mask_q) && !ext_out_reg_busy)
                        state_d = ST_FETCH;
                end
                ST_ERROR: begin
                    state_d = ST_ERROR;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            delay_q    <= '0;
            mask_q     <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            underrun_q <= 1'b0;
            error_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            delay_q    <= delay_d;
            mask_q     <= mask_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            underrun_q <= underrun_d;
            error_q    <= error_d;
            count_q    <= count_d;
        end
    end

    assign out_reg_write = wr_q;
    assign out_reg_addr  = addr_q;
    assign out_reg_data  = data_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign aborted       = aborted_q;
    assign underrun      = underrun_q;
    assign error         = error_q;
    assign cmd_count     = count_q;

endmodule

// File: tb/tb_buf_executor_mc.sv
// Scoreboard bench for buf_executor_mc: a FIFO model feeds programs, a reference
// model predicts writes and run latency, and a monitor checks every write.
module tb_buf_executor_mc;

    localparam int DW = 32;
    localparam int OW = 10;
    localparam int IW = 16;
    localparam int CW = 4;
    localparam int SL = 1;
    localparam int WW = OW + DW;

    typedef struct {
        logic [5:0]    a;
        logic [DW-1:0] d;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, start, abort, fifo_empty, fifo_read, ext_out_reg_busy;
    logic [WW-1:0] fifo_data;
    logic [CW-1:0] fifo_global_count, fifo_local_count, cmd_count;
    logic [IW-1:0] ext_pending_ints;
    logic [5:0]    out_reg_addr;
    logic [DW-1:0] out_reg_data;
    logic          out_reg_write, busy, done, aborted, underrun, error;

    logic [WW-1:0] fifo_q[$];
    exp_t          exp_q[$];
    longint        wr_cyc[$];
    longint        cyc = 0;
    int            total = 0;
    int            bad = 0;
    int            pop_cnt = 0;
    bit            do_pop;

    buf_executor_mc #(
        .DATA_WIDTH(DW), .OP_WIDTH(OW), .INT_WIDTH(IW), .COUNT_WIDTH(CW), .START_LEVEL(SL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read(fifo_read),
        .fifo_global_count(fifo_global_count), .fifo_local_count(fifo_local_count),
        .ext_out_reg_busy(ext_out_reg_busy), .ext_pending_ints(ext_pending_ints),
        .out_reg_addr(out_reg_addr), .out_reg_data(out_reg_data), .out_reg_write(out_reg_write),
        .busy(busy), .done(done), .aborted(aborted), .underrun(underrun), .error(error),
        .cmd_count(cmd_count)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endfunction

    // Monitor: every write the DUT presents must match the next predicted write.
    always @(negedge clk) begin
        if (rst && out_reg_write) begin
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_addr", out_reg_addr, e.a);
                chk("wr_data", out_reg_data, e.d);
            end
        end
    end

    function automatic void refresh();
        int n;
        n = fifo_q.size();
        fifo_empty        = (n == 0);
        fifo_data         = (n == 0) ? '0 : fifo_q[0];
        fifo_local_count  = (n > 15) ? 4'hF : CW'(n);
        fifo_global_count = fifo_local_count;
    endfunction

    function automatic void push(logic [WW-1:0] w);
        fifo_q.push_back(w);
        refresh();
    endfunction

    function automatic void flush();
        fifo_q.delete();
        refresh();
    endfunction

    function automatic logic [WW-1:0] mk(logic [7:0] op, logic [DW-1:0] pl);
        logic [OW-9:0] junk;
        junk = (OW-8)'($urandom);
        return {op, junk, pl};
    endfunction

    // Reference model: queues words, predicts writes up to END, returns pop-to-pop cost.
    function automatic void plan(input logic [WW-1:0] prog[$], output int cost);
        bit stop;
        exp_t e;
        cost = 0;
        stop = 0;
        foreach (prog[i]) begin
            logic [7:0]    op;
            logic [DW-1:0] pl;
            push(prog[i]);
            op = prog[i][WW-1 -: 8];
            pl = prog[i][DW-1:0];
            if (stop) continue;
            if (op < 8'h40) cost += 1 + int'(pl);
            else if (op < 8'h80) cost += 2;
            else if (op == 8'hBF || op >= 8'hC0) stop = 1;
            else begin
                cost += 1;
                e.a = op[5:0];
                e.d = pl;
                exp_q.push_back(e);
            end
        end
    endfunction

    // One clock: sample the pop decision before the edge, apply it to the FIFO model after.
    task automatic tick();
        #4;
        do_pop = fifo_read;
        @(posedge clk);
        #1;
        if (do_pop) begin
            if (fifo_q.size() == 0) chk("pop_on_empty", 1, 0);
            else begin
                void'(fifo_q.pop_front());
                pop_cnt++;
            end
        end
        refresh();
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget, input bit rnd_busy, input string name, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            if (rnd_busy) ext_out_reg_busy = ($urandom_range(0, 2) == 0);
            tick();
            cycles++;
        end
        ext_out_reg_busy = 1'b0;
        chk(name, done, 1);
    endtask

    task automatic run(input int budget, input bit rnd_busy, input string name, output int cycles);
        int c;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(budget, rnd_busy, name, c);
        cycles = c + 1;
    endtask

    initial begin
        logic [WW-1:0] prog[$];
        int cost, cyc_n, p0, n;
        exp_t e;

        rst = 1'b0; start = 1'b0; abort = 1'b0; ext_out_reg_busy = 1'b0;
        ext_pending_ints = '0;
        refresh();
        @(negedge clk);
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_write", out_reg_write, 0);
        chk("rst_count", cmd_count, 0);
        chk("rst_flags", {underrun, error, aborted}, 0);
        chk("rst_read", fifo_read, 0);
        rst = 1'b1;
        tick();

        // Basic OUT + END.
        prog = '{mk(8'h80, 32'h0), mk(8'hBF, 32'h0)};
        plan(prog, cost);
        run(40, 0, "t1_done", cyc_n);
        chk("t1_latency", cyc_n, cost + 3);
        chk("t1_count", cmd_count, 2);
        chk("t1_busy", busy, 0);
        tick();
        chk("t1_done_pulse", done, 0);

        // Output busy stalls the WAIT and the following OUT.
        wr_cyc.delete();
        prog = '{mk(8'h80, 32'h0), mk(8'h40, 32'h0), mk(8'h83, 32'h1), mk(8'hBF, 32'h0)};
        plan(prog, cost);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!out_reg_write && n < 20) begin tick(); n++; end
        chk("t2_first_wr", out_reg_write, 1);
        ext_out_reg_busy = 1'b1;
        repeat (5) tick();
        ext_out_reg_busy = 1'b0;
        wait_done(40, 0, "t2_done", cyc_n);
        chk("t2_wr_cnt", wr_cyc.size(), 2);
        if (wr_cyc.size() == 2) begin
            chk("t2_gap_min", (wr_cyc[1] - wr_cyc[0]) >= 5, 1);
            chk("t2_gap_max", (wr_cyc[1] - wr_cyc[0]) <= 7, 1);
        end

        // WAIT on an interrupt that arrives late.
        prog = '{mk(8'h40, 32'h1), mk(8'hBF, 32'h0)};
        plan(prog, cost);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        repeat (300) begin tick(); n += int'(done); end
        chk("t3_no_done", n, 0);
        chk("t3_busy", busy, 1);
        chk("t3_count", cmd_count, 1);
        ext_pending_ints = 16'h0001;
        wait_done(10, 0, "t3_done", cyc_n);
        chk("t3_latency", cyc_n, 2);
        ext_pending_ints = '1;
        tick();

        // Preload hold, underrun, reserved opcode, ignored start, abort.
        p0 = pop_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("t5_preload_busy", busy, 1);
        chk("t5_preload_nopop", pop_cnt, p0);
        chk("t5_preload_nounder", underrun, 0);
        prog = '{mk(8'h81, 32'h7)};
        plan(prog, cost);
        repeat (6) tick();
        chk("t5_pop1", pop_cnt, p0 + 1);
        chk("t5_underrun", underrun, 1);
        chk("t5_count1", cmd_count, 1);
        push(mk(8'hC0 + 8'($urandom_range(0, 63)), $urandom));
        repeat (3) tick();
        chk("t5_error", error, 1);
        chk("t5_count2", cmd_count, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t5_err_busy", busy, 1);
        chk("t5_err_start_ign", {underrun, error, cmd_count}, {2'b11, CW'(2)});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_aborted", aborted, 1);
        chk("t5_abort_idle", busy, 0);
        tick();
        chk("t5_aborted_pulse", aborted, 0);
        chk("t5_sticky", {underrun, error}, 2'b11);

        // Next start clears sticky flags and the counter.
        prog = '{mk(8'hBF, 32'h0)};
        plan(prog, cost);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_clear", {underrun, error, cmd_count}, '0);
        wait_done(10, 0, "t5b_done", cyc_n);

        // DELAY then OUT.
        prog = '{mk(8'h00, 32'hA), mk(8'h81, 32'hBEEF), mk(8'hBF, 32'h0)};
        plan(prog, cost);
        run(60, 0, "t4_done", cyc_n);
        chk("t4_latency", cyc_n, cost + 3);

        // Abort during a long DELAY.
        push(mk(8'h00, 32'd1000));
        push(mk(8'h80, 32'h5));
        push(mk(8'hBF, 32'h0));
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        chk("t6_count", cmd_count, 1);
        p0 = pop_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_idle", busy, 0);
        chk("t6_aborted", aborted, 1);
        repeat (10) tick();
        chk("t6_nopop", pop_cnt, p0);
        chk("t6_frozen", cmd_count, 1);
        flush();

        // Abort in the cycle a stalled OUT would have popped.
        push(mk(8'h85, $urandom));
        push(mk(8'hBF, 32'h0));
        ext_out_reg_busy = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        ext_out_reg_busy = 1'b0;
        abort = 1'b1;
        #1;
        chk("t7_abort_noread", fifo_read, 0);
        tick();
        abort = 1'b0;
        chk("t7_idle", busy, 0);
        repeat (3) tick();
        flush();

        // cmd_count saturation.
        prog.delete();
        for (int i = 0; i < 16; i++) prog.push_back(mk(8'h80 + 8'($urandom_range(0, 62)), $urandom));
        prog.push_back(mk(8'hBF, 32'h0));
        plan(prog, cost);
        run(60, 0, "t8_done", cyc_n);
        chk("t8_sat", cmd_count, 15);
        chk("t8_latency", cyc_n, cost + 3);

        // Reset mid-run drops the pending write.
        push(mk(8'h84, 32'h1234));
        push(mk(8'h80, 32'h55));
        e.a = 6'h04;
        e.d = 32'h1234;
        exp_q.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!out_reg_write && n < 20) begin tick(); n++; end
        chk("t9_wr", out_reg_write, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("t9_rst_state", {out_reg_write, busy, cmd_count}, '0);
        flush();
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Random programs: exact latency without busy, scoreboard only with random busy.
        ext_pending_ints = '1;
        for (int r = 0; r < 24; r++) begin
            int len;
            bit rb;
            rb = (r >= 12);
            len = $urandom_range(0, 7);
            prog.delete();
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 2))
                    0: prog.push_back(mk(8'h80 + 8'($urandom_range(0, 62)), $urandom));
                    1: prog.push_back(mk(8'($urandom_range(0, 63)), DW'($urandom_range(0, 4))));
                    default: prog.push_back(mk(8'h40 + 8'($urandom_range(0, 63)), $urandom));
                endcase
            end
            prog.push_back(mk(8'hBF, $urandom));
            plan(prog, cost);
            run(200, rb, "rnd_done", cyc_n);
            if (!rb) chk("rnd_latency", cyc_n, cost + 3);
            chk("rnd_count", cmd_count, len + 1);
            chk("rnd_fifo_drained", fifo_q.size(), 0);
            tick();
        end

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/buf_executor_mc.md
Name: buf_executor_mc

Overview:
Parametrised successor to the command-buffer executor. It pops opcode+payload command words from a first-word-fall-through (FWFT) command FIFO and drives a generic output-register write port. It can stall on output busy, interrupt masks or a programmed delay. New over the previous generation: configurable word and index widths, a FIFO preload threshold before a run starts, sticky underrun/error flags, a DELAY opcode and an executed-command counter.

Parameters:
DATA_WIDTH, 32, payload width; FIFO word = OP_WIDTH+DATA_WIDTH
OP_WIDTH, 8, opcode width, minimum 8; only the top 8 opcode bits are decoded
INT_WIDTH, 32, pending-interrupt vector width, ≤ DATA_WIDTH
COUNT_WIDTH, 32, width of FIFO counts and cmd_count
START_LEVEL, 1, minimum fifo_local_count before the first pop of a run; 0 disables preload

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  begin run (honoured only in IDLE)
abort  in  1  terminate run from any state
fifo_empty  in  1  FIFO empty
fifo_data  in  OP_WIDTH+DATA_WIDTH  FWFT head word, opcode in MSBs
fifo_read  out  1  pop strobe, combinational
fifo_global_count  in  COUNT_WIDTH  total buffered words, status only
fifo_local_count  in  COUNT_WIDTH  words in local FIFO
ext_out_reg_busy  in  1  output consumer cannot accept a write
ext_pending_ints  in  INT_WIDTH  interrupt lines
out_reg_addr  out  6  output register index
out_reg_data  out  DATA_WIDTH  output register data
out_reg_write  out  1  one-cycle write strobe
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on END
aborted  out  1  one-cycle pulse on abort
underrun  out  1  sticky: FIFO empty while in FETCH
error  out  1  sticky: reserved opcode popped
cmd_count  out  COUNT_WIDTH  commands popped in current run

Behaviour:
- Reset: state IDLE. All outputs 0, including cmd_count and the delay counter.
- Opcode decode (op = fifo_data[top 8 bits]):
  - 00-3F: DELAY payload cycles (0 = no delay).
  - 40-7F: WAIT until (ext_pending_ints & mask) == mask and !ext_out_reg_busy, where mask = payload[INT_WIDTH-1:0].
  - 80-BE: OUT, write payload to index op[5:0].
  - BF: END.
  - C0-FF: reserved.
- IDLE: start=1 -> PRELOAD. The same edge clears underrun, error and cmd_count.
- PRELOAD: fifo_local_count >= START_LEVEL -> FETCH. There is no timeout. The host guarantees programs of at least START_LEVEL words.
- FETCH, fifo_empty=1: no pop; set underrun; remain in FETCH.
- FETCH, OUT with ext_out_reg_busy=1: no pop; stall.
- FETCH, OUT with busy=0: pop. On the next cycle out_reg_write=1 with addr/data registered. Sustained throughput is one OUT per cycle.
- FETCH, DELAY: pop. Payload 0 stays in FETCH; otherwise load counter = payload-1 -> DELAY.
- DELAY: count down; at 0 -> FETCH. Payload N costs exactly N stall cycles.
- FETCH, WAIT: pop -> WAIT_INT. WAIT_INT -> FETCH on the first cycle the condition holds; it is sampled every cycle and a mask of 0 waits only on busy.
- FETCH, END: pop -> IDLE; done=1 on the next cycle.
- FETCH, reserved: pop -> ERROR; error=1. ERROR is left only by abort; start is ignored there.
- cmd_count increments on every pop and saturates at its maximum.
- abort: has priority over start and over every decode. Next state is IDLE, and fifo_read is 0 in the abort cycle. No out_reg_write follows, except one already registered. aborted pulses for one cycle. Sticky flags are held.
- start while busy: ignored.
- rst low mid-run: immediate return to reset values. Any pending write is dropped.

Decomposition:
- Shared header buf_exec_defs.vh holds the opcode class constants (DELAY, WAIT, OUT, END=8'hBF, reserved), the state encodings and the END index 6'h3F.
- One natural sub-module, buf_exec_decode: combinational opcode classification plus payload/mask extraction, reused by the executor and the bench checker.

Test Plan:
- Push 80_00000000, BF_00000000; start; START_LEVEL=1 -> one write, addr 0 data 0; done pulse; cmd_count=2; busy low afterwards.
- Push 80_00000000, 40_00000000, 83_00000001, BF_00000000 with ext_out_reg_busy held high 5 cycles after the first write -> write to addr 3 data 1 appears ≥5 cycles after the addr 0 write; done.
- Program 40_00000001, BF; ints=0 -> stays in WAIT_INT 300 cycles; pending_ints=1 -> done 2 cycles later.
- Program 00_0000000A, 81_0000BEEF, BF -> exactly 10 stall cycles, then write addr 1 data BEEF.
- Start with FIFO empty (START_LEVEL=0) -> underrun=1, no pops. Push C0_00000000 -> error=1, state ERROR; start ignored; abort -> aborted pulse, busy=0.
- Abort during DELAY of 1000 -> IDLE next cycle, fifo_read never asserted after the abort, cmd_count frozen.
